ray_gen_pipe: RTL and testbench
===============================

Name: ray_gen_pipe

Overview:
- Parametrised, pipelined primary-ray generator for the multi-core ray tracer.
- Each instance walks its interleaved share of the image: pixels core_id, core_id+num_cores, and so on.
- Emits one camera-space ray direction per pixel on a valid/ready stream.
- Replaces per-pixel divide/modulo with incremental x/y counters and adds backpressure, abort, config checking and optional saturation.

Parameters:
- COORD_W, 12, width of signed camera vector components and ray outputs.
- DIM_W, 13, width of unsigned image_width/image_height.
- IDX_W, 32, width of pixel index output.
- MAX_CORES, 8, largest legal num_cores; CORE_W = $clog2(MAX_CORES+1).
- SATURATE, 0, 1 = clamp ray components to COORD_W signed range; 0 = two's-complement truncation.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  synchronous flush back to IDLE.
- cam_dir_{x,y,z}, cam_right_{x,y,z}, cam_up_{x,y,z}  in  COORD_W each  signed camera basis.
- image_width, image_height  in  DIM_W  unsigned image size.
- core_id  in  CORE_W  this core's index.
- num_cores  in  CORE_W  total interleaved cores.
- out_valid  out  1  ray available.
- out_ready  in  1  consumer accepts the ray when out_valid && out_ready.
- ray_dir_{x,y,z}  out  COORD_W each  signed ray direction.
- pixel_index  out  IDX_W  linear pixel index of the current ray.
- pixel_x, pixel_y  out  DIM_W each  pixel coordinates of the current ray.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  one-cycle pulse with done on illegal configuration.

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline empty. Reset mid-frame discards everything with no done pulse.
- States: IDLE, SETUP, RUN, DRAIN, FIN.
- IDLE:
  - On start, latch all camera, size and core inputs; later input changes are ignored until the next start. Go to SETUP.
  - start is ignored in any state other than IDLE.
- SETUP (1 cycle):
  - Init x=core_id, y=0, idx=core_id, total=image_width*image_height.
  - Error if width==0, height==0, num_cores==0, num_cores>MAX_CORES, core_id>=num_cores, or num_cores>width: go to FIN with cfg_err.
  - Else if core_id>=total: go to FIN with no rays.
  - Else go to RUN.
- Pipeline advance: adv = !out_valid || out_ready.
- RUN (per cycle with adv):
  - Issue (idx,x,y) into stage 1.
  - Advance counters: idx+=num_cores; xn=x+num_cores; if xn>=width then x=xn-width, y=y+1, else x=xn.
  - If idx+num_cores>=total, this is the last issue; go to DRAIN.
- Stage 1 registers:
  - u = x - (width>>1) and v = (height>>1) - y, both signed DIM_W+2 bits.
  - Also registers idx, x, y and a valid bit.
- Stage 2 (output register, loads when adv):
  - r = right*u + up*v + dir per component, computed at full width COORD_W+DIM_W+3 bits.
  - Output = low COORD_W bits, or clamped to [-2^(COORD_W-1), 2^(COORD_W-1)-1] if SATURATE.
  - Sets out_valid.
- Output handshake:
  - Output holds stable while out_valid && !out_ready.
  - When adv and stage 1 is empty, out_valid clears.
- Latency: start at cycle T gives first out_valid at T+4 (SETUP T+1, RUN issue T+2, stage 1 T+3, output T+4), given no stall.
- Throughput: one ray per cycle under continuous out_ready.
- DRAIN: stay until stage 1 is empty and the final ray has been accepted, then go to FIN.
- FIN (1 cycle): done=1 (cfg_err=1 if error). Go to IDLE.
- abort (any non-IDLE state, including same cycle as a handshake): next cycle is IDLE, out_valid=0, pipeline cleared, no done. abort outranks all other events.
- Rays leave in strictly increasing pixel_index order; no drops, no duplicates.

Test Plan:
- 4x2 image, num_cores=1, core_id=0, right=(1,0,0), up=(0,1,0), dir=(0,0,5), out_ready=1 -> 8 rays, pixel 0 = (-2,1,5), pixel 3 = (1,1,5), pixel 7 = (1,0,5); first valid at start+4; done one cycle after last handshake.
- Same camera, 4x2, num_cores=3, core_id=2 -> exactly 2 rays: idx 2 (x2,y0) = (0,1,5) and idx 5 (x1,y1) = (-1,0,5); then done.
- 8x1, right=(1000,0,0), up=0, dir=0, pixel x=7 (u=3) -> SATURATE=1 gives 2047; SATURATE=0 gives -1096.
- Random out_ready with low runs of up to 5 cycles, 16x4, num_cores=1 -> 64 rays in order, outputs stable while stalled, values match the reference model.
- num_cores=0, then separately num_cores=5 with width=4 -> no out_valid; done and cfg_err pulse together 2 cycles after start; start while busy is ignored.
- abort asserted after 3 rays of a 4x2 frame, and separately reset_n low mid-frame -> out_valid=0 and busy=0 next cycle, no done; a fresh start regenerates from pixel core_id.

Source files
------------

// File: rtl/ray_gen_pipe.sv
// Pipelined primary-ray generator. Each instance walks its interleaved share of
// the image (pixels core_id, core_id+num_cores, ...) using incremental x/y
// counters and emits one camera-space ray direction per pixel on a valid/ready
// stream.
module ray_gen_pipe #(
    parameter int unsigned COORD_W   = 12,
    parameter int unsigned DIM_W     = 13,
    parameter int unsigned IDX_W     = 32,
    parameter int unsigned MAX_CORES = 8,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned CORE_W    = $clog2(MAX_CORES + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [COORD_W-1:0] cam_dir_x,
    input  logic signed [COORD_W-1:0] cam_dir_y,
    input  logic signed [COORD_W-1:0] cam_dir_z,
    input  logic signed [COORD_W-1:0] cam_right_x,
    input  logic signed [COORD_W-1:0] cam_right_y,
    input  logic signed [COORD_W-1:0] cam_right_z,
    input  logic signed [COORD_W-1:0] cam_up_x,
    input  logic signed [COORD_W-1:0] cam_up_y,
    input  logic signed [COORD_W-1:0] cam_up_z,
    input  logic        [DIM_W-1:0]   image_width,
    input  logic        [DIM_W-1:0]   image_height,
    input  logic        [CORE_W-1:0]  core_id,
    input  logic        [CORE_W-1:0]  num_cores,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] ray_dir_x,
    output logic signed [COORD_W-1:0] ray_dir_y,
    output logic signed [COORD_W-1:0] ray_dir_z,
    output logic        [IDX_W-1:0]   pixel_index,
    output logic        [DIM_W-1:0]   pixel_x,
    output logic        [DIM_W-1:0]   pixel_y,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int unsigned UV_W  = DIM_W + 2;
    localparam int unsigned RW    = COORD_W + DIM_W + 3;
    localparam int unsigned TOT_W = 2 * DIM_W;
    localparam int unsigned CMP_W = ((IDX_W > TOT_W) ? IDX_W : TOT_W) + 1;
    localparam int unsigned CW2_W = DIM_W + CORE_W;

    localparam logic signed [RW-1:0] SAT_MAX = {{(RW - COORD_W + 1){1'b0}}, {(COORD_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state_q;

    // Latched frame configuration
    logic signed [COORD_W-1:0] dir_q   [3];
    logic signed [COORD_W-1:0] right_q [3];
    logic signed [COORD_W-1:0] up_q    [3];
    logic        [DIM_W-1:0]   width_q;
    logic        [DIM_W-1:0]   height_q;
    logic        [CORE_W-1:0]  core_q;
    logic        [CORE_W-1:0]  ncores_q;

    // Pixel walk counters
    logic [DIM_W-1:0] x_q;
    logic [DIM_W-1:0] y_q;
    logic [IDX_W-1:0] idx_q;
    logic [TOT_W-1:0] total_q;

    // Stage 1: screen-space offsets
    logic                   s1_valid_q;
    logic [IDX_W-1:0]       s1_idx_q;
    logic [DIM_W-1:0]       s1_x_q;
    logic [DIM_W-1:0]       s1_y_q;
    logic signed [UV_W-1:0] s1_u_q;
    logic signed [UV_W-1:0] s1_v_q;

    // Stage 2: output register
    logic                      out_valid_q;
    logic signed [COORD_W-1:0] ray_q [3];
    logic [IDX_W-1:0]          pix_idx_q;
    logic [DIM_W-1:0]          pix_x_q;
    logic [DIM_W-1:0]          pix_y_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      cfg_err_q;

    logic                      adv_c;
    logic [DIM_W:0]            xn_c;
    logic                      wrap_c;
    logic                      last_c;
    logic [TOT_W-1:0]          total_c;
    logic                      cfg_bad_c;
    logic                      empty_c;
    logic signed [RW-1:0]      r_c   [3];
    logic signed [COORD_W-1:0] ray_c [3];

    // Pipeline advance, counter stepping and configuration checks
    always_comb begin
        adv_c     = !out_valid_q || out_ready;
        xn_c      = (DIM_W + 1)'(x_q) + (DIM_W + 1)'(ncores_q);
        wrap_c    = xn_c >= (DIM_W + 1)'(width_q);
        last_c    = (CMP_W'(idx_q) + CMP_W'(ncores_q)) >= CMP_W'(total_q);
        total_c   = TOT_W'(width_q) * TOT_W'(height_q);
        cfg_bad_c = (width_q == '0) || (height_q == '0) || (ncores_q == '0)
                  || (ncores_q > CORE_W'(MAX_CORES)) || (core_q >= ncores_q)
                  || (CW2_W'(ncores_q) > CW2_W'(width_q));
        empty_c   = CMP_W'(core_q) >= CMP_W'(total_c);
    end

    // Ray direction r = right*u + up*v + dir at full width, then wrap or clamp
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            r_c[i]   = RW'(right_q[i]) * RW'(s1_u_q) + RW'(up_q[i]) * RW'(s1_v_q) + RW'(dir_q[i]);
            ray_c[i] = COORD_W'(r_c[i]);
            if (SATURATE != 0) begin
                if (r_c[i] > SAT_MAX) begin
                    ray_c[i] = COORD_W'(SAT_MAX);
                end else if (r_c[i] < SAT_MIN) begin
                    ray_c[i] = COORD_W'(SAT_MIN);
                end
            end
        end
    end

    // Control FSM, counters and both pipeline stages
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            core_q      <= '0;
            ncores_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            total_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_u_q      <= '0;
            s1_v_q      <= '0;
            out_valid_q <= 1'b0;
            pix_idx_q   <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dir_q[i]   <= '0;
                right_q[i] <= '0;
                up_q[i]    <= '0;
                ray_q[i]   <= '0;
            end
        end else if (abort && (state_q != S_IDLE)) begin
            state_q     <= S_IDLE;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;

            if (adv_c) begin
                s1_valid_q  <= 1'b0;
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    pix_idx_q <= s1_idx_q;
                    pix_x_q   <= s1_x_q;
                    pix_y_q   <= s1_y_q;
                    for (int i = 0; i < 3; i++) begin
                        ray_q[i] <= ray_c[i];
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dir_q[0]   <= cam_dir_x;
                        dir_q[1]   <= cam_dir_y;
                        dir_q[2]   <= cam_dir_z;
                        right_q[0] <= cam_right_x;
                        right_q[1] <= cam_right_y;
                        right_q[2] <= cam_right_z;
                        up_q[0]    <= cam_up_x;
                        up_q[1]    <= cam_up_y;
                        up_q[2]    <= cam_up_z;
                        width_q    <= image_width;
                        height_q   <= image_height;
                        core_q     <= core_id;
                        ncores_q   <= num_cores;
                        state_q    <= S_SETUP;
                        busy_q     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    x_q     <= DIM_W'(core_q);
                    y_q     <= '0;
                    idx_q   <= IDX_W'(core_q);
                    total_q <= total_c;
                    if (cfg_bad_c) begin
                        state_q   <= S_FIN;
                        done_q    <= 1'b1;
                        cfg_err_q <= 1'b1;
                    end else if (empty_c) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (adv_c) begin
                        s1_valid_q <= 1'b1;
                        s1_idx_q   <= idx_q;
                        s1_x_q     <= x_q;
                        s1_y_q     <= y_q;
                        s1_u_q     <= UV_W'(x_q) - UV_W'(width_q >> 1);
                        s1_v_q     <= UV_W'(height_q >> 1) - UV_W'(y_q);
                        idx_q      <= idx_q + IDX_W'(ncores_q);
                        if (wrap_c) begin
                            x_q <= DIM_W'(xn_c - (DIM_W + 1)'(width_q));
                            y_q <= y_q + DIM_W'(1);
                        end else begin
                            x_q <= DIM_W'(xn_c);
                        end
                        if (last_c) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final ray sits in the output register and is being taken
                    if (!s1_valid_q && adv_c) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign ray_dir_x   = ray_q[0];
    assign ray_dir_y   = ray_q[1];
    assign ray_dir_z   = ray_q[2];
    assign pixel_index = pix_idx_q;
    assign pixel_x     = pix_x_q;
    assign pixel_y     = pix_y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_ray_gen_pipe.sv
// Directed bench for ray_gen_pipe: one wrapping instance and one saturating
// instance share all inputs.
module tb_ray_gen_pipe;

    logic clk;
    logic reset_n, start, abort, out_ready;
    logic signed [11:0] cam_dir_x, cam_dir_y, cam_dir_z;
    logic signed [11:0] cam_right_x, cam_right_y, cam_right_z;
    logic signed [11:0] cam_up_x, cam_up_y, cam_up_z;
    logic [12:0] image_width, image_height;
    logic [3:0]  core_id, num_cores;

    logic               out_valid, busy, done, cfg_err;
    logic signed [11:0] ray_dir_x, ray_dir_y, ray_dir_z;
    logic [31:0]        pixel_index;
    logic [12:0]        pixel_x, pixel_y;

    logic               s_out_valid, s_busy, s_done, s_cfg_err;
    logic signed [11:0] s_ray_dir_x, s_ray_dir_y, s_ray_dir_z;
    logic [31:0]        s_pixel_index;
    logic [12:0]        s_pixel_x, s_pixel_y;

    int n_chk  = 0;
    int n_fail = 0;

    int n, cyc, low;
    int ex, ey, eu, ev;
    logic held;
    logic [31:0] h_idx;
    logic signed [11:0] h_x, h_y, h_z;

    ray_gen_pipe #(.SATURATE(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cam_dir_x(cam_dir_x), .cam_dir_y(cam_dir_y), .cam_dir_z(cam_dir_z),
        .cam_right_x(cam_right_x), .cam_right_y(cam_right_y), .cam_right_z(cam_right_z),
        .cam_up_x(cam_up_x), .cam_up_y(cam_up_y), .cam_up_z(cam_up_z),
        .image_width(image_width), .image_height(image_height),
        .core_id(core_id), .num_cores(num_cores),
        .out_valid(out_valid), .out_ready(out_ready),
        .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
        .pixel_index(pixel_index), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    ray_gen_pipe #(.SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cam_dir_x(cam_dir_x), .cam_dir_y(cam_dir_y), .cam_dir_z(cam_dir_z),
        .cam_right_x(cam_right_x), .cam_right_y(cam_right_y), .cam_right_z(cam_right_z),
        .cam_up_x(cam_up_x), .cam_up_y(cam_up_y), .cam_up_z(cam_up_z),
        .image_width(image_width), .image_height(image_height),
        .core_id(core_id), .num_cores(num_cores),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .ray_dir_x(s_ray_dir_x), .ray_dir_y(s_ray_dir_y), .ray_dir_z(s_ray_dir_z),
        .pixel_index(s_pixel_index), .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
        .busy(s_busy), .done(s_done), .cfg_err(s_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ray(input string tag, input int idx, input int x, input int y,
                           input int rx, input int ry, input int rz);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_idx"}, pixel_index, idx);
        chk({tag, "_px"}, pixel_x, x);
        chk({tag, "_py"}, pixel_y, y);
        chk({tag, "_rx"}, ray_dir_x, rx);
        chk({tag, "_ry"}, ray_dir_y, ry);
        chk({tag, "_rz"}, ray_dir_z, rz);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (out_valid !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int cid, input int nc);
        image_width  = 13'(w);
        image_height = 13'(h);
        core_id      = 4'(cid);
        num_cores    = 4'(nc);
    endtask

    task automatic set_cam(input int rx, input int ry, input int rz, input int ux, input int uy,
                           input int uz, input int dx, input int dy, input int dz);
        cam_right_x = 12'(rx); cam_right_y = 12'(ry); cam_right_z = 12'(rz);
        cam_up_x    = 12'(ux); cam_up_y    = 12'(uy); cam_up_z    = 12'(uz);
        cam_dir_x   = 12'(dx); cam_dir_y   = 12'(dy); cam_dir_z   = 12'(dz);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        set_cam(1, 0, 0, 0, 1, 0, 0, 0, 5);
        set_cfg(4, 2, 0, 1);
        tick(); tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_idx", pixel_index, 0);
        chk("rst_rx", ray_dir_x, 0);
        chk("rst_sat_valid", s_out_valid, 0);
        reset_n = 1'b1;
        tick();

        // 4x2 single core: latency, throughput, done timing
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_v_t1", out_valid, 0);
        tick(); chk("t1_v_t2", out_valid, 0);
        tick(); chk("t1_v_t3", out_valid, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_ray($sformatf("t1_r%0d", i), i, i % 4, i / 4, (i % 4) - 2, 1 - (i / 4), 5);
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_cfg_err", cfg_err, 0);
        chk("t1_v_end", out_valid, 0);
        tick();
        chk("t1_done_off", done, 0);
        chk("t1_busy_off", busy, 0);

        // 4x2, three cores, this is core 2
        set_cfg(4, 2, 2, 3);
        pulse_start();
        tick(); tick(); tick();
        chk_ray("t2_a", 2, 2, 0, 0, 1, 5);
        tick();
        chk_ray("t2_b", 5, 1, 1, -1, 0, 5);
        tick();
        chk("t2_done", done, 1);
        chk("t2_v_end", out_valid, 0);
        tick();
        chk("t2_busy_off", busy, 0);

        // Wrap versus clamp on overflowing component
        set_cfg(8, 1, 0, 1);
        set_cam(1000, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse_start();
        wait_valid();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_idx%0d", i), pixel_index, i);
            chk($sformatf("t3_sidx%0d", i), s_pixel_index, i);
            if (i == 0) begin
                chk("t3_wrap_x0", ray_dir_x, 96);
                chk("t3_sat_x0", s_ray_dir_x, -2048);
            end
            if (i == 5) begin
                chk("t3_wrap_x5", ray_dir_x, 1000);
                chk("t3_sat_x5", s_ray_dir_x, 1000);
            end
            if (i == 7) begin
                chk("t3_wrap_x7", ray_dir_x, -1096);
                chk("t3_sat_x7", s_ray_dir_x, 2047);
                chk("t3_sat_y7", s_ray_dir_y, 0);
            end
            tick();
        end
        chk("t3_done", done, 1);
        chk("t3_sat_done", s_done, 1);

        // 16x4 under random backpressure; mid-frame start must be ignored
        set_cfg(16, 4, 0, 1);
        set_cam(3, -2, 1, 1, 4, -2, 7, -5, 9);
        pulse_start();
        n = 0; cyc = 0; low = 0; held = 1'b0;
        while (n < 64 && cyc < 3000) begin
            if (low > 0) begin
                out_ready = 1'b0;
                low--;
            end else if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                low = int'($urandom_range(0, 4));
            end else begin
                out_ready = 1'b1;
            end
            start = (cyc == 20);
            if (held) begin
                chk("t4_hold_v", out_valid, 1);
                chk("t4_hold_idx", pixel_index, h_idx);
                chk("t4_hold_rx", ray_dir_x, h_x);
                chk("t4_hold_ry", ray_dir_y, h_y);
                chk("t4_hold_rz", ray_dir_z, h_z);
            end
            if (out_valid && out_ready) begin
                ex = n % 16; ey = n / 16; eu = ex - 8; ev = 2 - ey;
                chk_ray($sformatf("t4_r%0d", n), n, ex, ey,
                        3 * eu + ev + 7, -2 * eu + 4 * ev - 5, eu - 2 * ev + 9);
                n++;
            end
            held  = out_valid && !out_ready;
            h_idx = pixel_index;
            h_x   = ray_dir_x;
            h_y   = ray_dir_y;
            h_z   = ray_dir_z;
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("t4_count", n, 64);
        chk("t4_done", done, 1);
        tick();

        // Illegal configs: num_cores=0, then num_cores > width
        set_cam(1, 0, 0, 0, 1, 0, 0, 0, 5);
        set_cfg(4, 2, 0, 0);
        pulse_start();
        start = 1'b1;
        chk("t5a_done_t1", done, 0);
        chk("t5a_busy_t1", busy, 1);
        tick();
        start = 1'b0;
        chk("t5a_done", done, 1);
        chk("t5a_cfg_err", cfg_err, 1);
        chk("t5a_valid", out_valid, 0);
        tick();
        chk("t5a_done_off", done, 0);
        chk("t5a_busy_off", busy, 0);
        tick();
        chk("t5a_ignored_start", busy, 0);
        set_cfg(4, 2, 0, 5);
        pulse_start();
        chk("t5b_valid", out_valid, 0);
        tick();
        chk("t5b_done", done, 1);
        chk("t5b_cfg_err", cfg_err, 1);
        tick();
        chk("t5b_busy_off", busy, 0);

        // Abort after three rays, then restart as core 1 of 2
        set_cfg(4, 2, 0, 1);
        pulse_start();
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk_ray($sformatf("t6_r%0d", i), i, i, 0, i - 2, 1, 5);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_valid", out_valid, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6_quiet_done%0d", i), done, 0);
            chk($sformatf("t6_quiet_valid%0d", i), out_valid, 0);
        end
        set_cfg(4, 2, 1, 2);
        pulse_start();
        tick(); tick(); tick();
        chk_ray("t6_f0", 1, 1, 0, -1, 1, 5); tick();
        chk_ray("t6_f1", 3, 3, 0, 1, 1, 5);  tick();
        chk_ray("t6_f2", 5, 1, 1, -1, 0, 5); tick();
        chk_ray("t6_f3", 7, 3, 1, 1, 0, 5);  tick();
        chk("t6_done", done, 1);
        tick();

        // Reset mid-frame, then a full clean frame
        set_cfg(4, 2, 0, 1);
        pulse_start();
        tick(); tick(); tick();
        chk_ray("t7_r0", 0, 0, 0, -2, 1, 5); tick();
        chk_ray("t7_r1", 1, 1, 0, -1, 1, 5); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_idx", pixel_index, 0);
        tick();
        chk("t7_quiet_done", done, 0);
        pulse_start();
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            chk_ray($sformatf("t7_f%0d", i), i, i % 4, i / 4, (i % 4) - 2, 1 - (i / 4), 5);
            tick();
        end
        chk("t7_done", done, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
